// File: rtl/lfsr_pattern_ctrl.sv
// Burst sequencer for an external WIDTH-bit XNOR LFSR: seed load, back-pressured stepping, bit framing.
// Optional period detector enabled by defining PERIOD_CHECK_EN.
module lfsr_pattern_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_bits,
    input  logic             abort,
    input  logic             line_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bits_sent,
    output logic             line_bit,
    output logic             line_valid,
    output logic             lfsr_load,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic             lfsr_enable,
    input  logic             lfsr_lineout,
    input  logic [WIDTH-1:0] lfsr_state,
    output logic             period_hit,
    output logic [CNT_W-1:0] period_len
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_LOAD  | LFSR loads the captured seed
    // S_RUN   | stepping the LFSR whenever the line is ready
    // S_DRAIN | last requested bit is on the line
    // S_DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] seed_fix;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] bits_cnt;
    logic             line_valid_q;
    logic             zero_done_q;
    logic             accept;
    logic             accept_zero;

    // All-ones locks an XNOR LFSR; nudge it to the nearest live state.
    assign seed_fix = (seed == {WIDTH{1'b1}}) ? {{(WIDTH-1){1'b1}}, 1'b0} : seed;

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        accept_zero = 1'b0;
        lfsr_enable = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (num_bits != '0) begin
                        accept    = 1'b1;
                        state_nxt = S_LOAD;
                    end else begin
                        accept_zero = 1'b1;
                    end
                end
            end
            S_LOAD:  state_nxt = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    lfsr_enable = line_ready && (remaining != '0);
                    if (lfsr_enable && (remaining == CNT_W'(1))) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: state_nxt = abort ? S_IDLE : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            seed_q       <= '0;
            remaining    <= '0;
            bits_cnt     <= '0;
            line_valid_q <= 1'b0;
            zero_done_q  <= 1'b0;
        end else begin
            state        <= state_nxt;
            line_valid_q <= lfsr_enable;
            zero_done_q  <= accept_zero;
            if (accept) begin
                seed_q    <= seed_fix;
                remaining <= num_bits;
                bits_cnt  <= '0;
            end else if (accept_zero) begin
                bits_cnt <= '0;
            end else begin
                if (lfsr_enable) remaining <= remaining - CNT_W'(1);
                if (line_valid_q) bits_cnt <= bits_cnt + CNT_W'(1);
            end
        end
    end

    assign busy       = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
    assign done       = (state == S_DONE) || zero_done_q;
    assign bits_sent  = bits_cnt;
    assign line_valid = line_valid_q;
    assign line_bit   = lfsr_lineout & line_valid_q;
    assign lfsr_load  = (state == S_LOAD);
    assign lfsr_seed  = seed_q;

`ifdef PERIOD_CHECK_EN
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] period_q;
    logic             hit_q;
    logic             found_q;

    // step_cnt and lfsr_state advance on the same edge, so they always describe the same step.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt <= '0;
            period_q <= '0;
            hit_q    <= 1'b0;
            found_q  <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            if (state == S_LOAD) begin
                step_cnt <= '0;
                period_q <= '0;
                found_q  <= 1'b0;
            end else begin
                if (lfsr_enable) step_cnt <= step_cnt + CNT_W'(1);
                if (!found_q && ((state == S_RUN) || (state == S_DRAIN)) &&
                    (step_cnt != '0) && (lfsr_state == seed_q)) begin
                    found_q  <= 1'b1;
                    hit_q    <= 1'b1;
                    period_q <= step_cnt;
                end
            end
        end
    end

    assign period_hit = hit_q;
    assign period_len = period_q;
`else
    logic unused_lfsr_state;
    assign unused_lfsr_state = ^lfsr_state;
    assign period_hit = 1'b0;
    assign period_len = '0;
`endif

endmodule

// File: tb/tb_lfsr_pattern_ctrl.sv
// Self-checking bench for lfsr_pattern_ctrl: behavioural LFSR on the far side, burst-level model, directed vectors.
module tb_lfsr_pattern_ctrl;
    localparam int W  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset, start, abort, line_ready;
    logic [W-1:0]  seed;
    logic [CW-1:0] num_bits;
    logic          busy, done, line_bit, line_valid, lfsr_load, lfsr_enable, period_hit;
    logic [CW-1:0] bits_sent, period_len;
    logic [W-1:0]  lfsr_seed;
    logic          lfsr_lineout = 1'b0;
    logic [W-1:0]  lfsr_state = '0;

    lfsr_pattern_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed), .num_bits(num_bits),
        .abort(abort), .line_ready(line_ready), .busy(busy), .done(done),
        .bits_sent(bits_sent), .line_bit(line_bit), .line_valid(line_valid),
        .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_enable(lfsr_enable),
        .lfsr_lineout(lfsr_lineout), .lfsr_state(lfsr_state),
        .period_hit(period_hit), .period_len(period_len)
    );

    always #5 clk = ~clk;

    // The LFSR being controlled: XNOR of bits 0 and 1 fed into the MSB, registered lineout.
    always @(posedge clk) begin
        if (lfsr_load) begin
            lfsr_state   <= lfsr_seed;
            lfsr_lineout <= 1'b0;
        end else if (lfsr_enable) begin
            lfsr_state   <= {lfsr_state[0] ~^ lfsr_state[1], lfsr_state[W-1:1]};
            lfsr_lineout <= lfsr_state[1];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: the pattern as an integer recurrence; bit k of a burst is bit0 after k steps.
    function automatic int lfsr_step(input int s);
        int fb;
        fb = (((s & 1) == ((s >> 1) & 1)) ? 1 : 0);
        return (s >> 1) | (fb << (W - 1));
    endfunction

    function automatic logic ref_bit(input logic [W-1:0] s0, input int k);
        int s = int'(s0);
        for (int i = 0; i < k; i++) s = lfsr_step(s);
        return logic'(s & 1);
    endfunction

    function automatic int ref_period(input logic [W-1:0] s0);
        int s = int'(s0);
        for (int i = 1; i <= (1 << W); i++) begin
            s = lfsr_step(s);
            if (s == int'(s0)) return i;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] fix_seed(input logic [W-1:0] s);
        return (s == {W{1'b1}}) ? s - W'(1) : s;
    endfunction

    logic [W-1:0] m_seed  = '0;
    int           m_len   = 0;
    int           m_idx   = 0;
    bit           m_track = 1'b0;

    always @(negedge clk) begin
        if (lfsr_enable) chk("enable_needs_ready", line_ready, 1);
        if (m_track && (busy || done)) chk("bits_sent_track", bits_sent, m_idx);
        if (!m_track) begin
            chk("valid_outside_burst", line_valid, 0);
            if (done) chk("done_outside_burst", done, 0);
        end else begin
            if (line_valid) begin
                chk("line_bit_model", line_bit, ref_bit(m_seed, m_idx + 1));
                m_idx++;
            end
            if (done) chk("done_bit_count", m_idx, m_len);
        end
    end

    int          first_v, last_v, n_v, done_c, busy_n, hit_n, hit_c;
    logic [31:0] bits_got;
    logic        load_seen;
    logic [W-1:0] seed_seen;

    task automatic launch(input logic [W-1:0] s, input int n, input bit ab);
        start    = 1'b1;
        seed     = s;
        num_bits = CW'(n);
        abort    = ab;
        m_seed   = fix_seed(s);
        m_len    = n;
        m_idx    = 0;
        m_track  = !ab;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic observe(input int max_c, input int rlo_from, input int rlo_to,
                           input int abort_at, input int reset_at, input int start_at);
        first_v = -1; last_v = -1; n_v = 0; done_c = -1; busy_n = 0;
        hit_n = 0; hit_c = -1; bits_got = '0; load_seen = 1'b0; seed_seen = '0;
        for (int c = 1; c <= max_c; c++) begin
            line_ready = !(c >= rlo_from && c <= rlo_to);
            abort      = (abort_at > 0) && (c == abort_at);
            reset      = (reset_at > 0) && (c == reset_at);
            start      = (start_at > 0) && (c == start_at);
            if (start) num_bits = CW'(2);
            if ((abort_at > 0 && c == abort_at + 1) || (reset_at > 0 && c == reset_at + 1))
                m_track = 1'b0;
            @(negedge clk);
            if (line_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                if (n_v < 32) bits_got[n_v] = line_bit;
                n_v++;
            end
            if (done && done_c < 0) done_c = c;
            if (busy) busy_n++;
            if (period_hit) begin
                hit_n++;
                hit_c = c;
            end
            if (c == 1) begin
                load_seen = lfsr_load;
                seed_seen = lfsr_seed;
            end
            if (abort_at > 0 && c == abort_at) chk("abort_enable_low", lfsr_enable, 0);
            if (abort_at > 0 && c == abort_at + 1) begin
                chk("abort_idle_busy", busy, 0);
                chk("abort_valid_low", line_valid, 0);
            end
            if (reset_at > 0 && c == reset_at + 1)
                chk("reset_mid_run_outputs",
                    {busy, done, bits_sent, line_bit, line_valid, lfsr_load, lfsr_seed,
                     lfsr_enable, period_hit, period_len}, 0);
            @(posedge clk);
            #1;
        end
        abort = 1'b0; reset = 1'b0; start = 1'b0; line_ready = 1'b1;
        m_track = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; line_ready = 1'b1;
        seed = '0; num_bits = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {busy, done, bits_sent, line_bit, line_valid, lfsr_load,
                              lfsr_seed, lfsr_enable, period_hit, period_len}, 0);
        @(posedge clk);
        #1;

        // seed 0, 4 bits, ready throughout
        launch(4'b0000, 4, 1'b0);
        observe(10, 0, -1, 0, 0, 0);
        chk("t1_load", load_seen, 1);
        chk("t1_first_valid", first_v, 3);
        chk("t1_last_valid", last_v, 6);
        chk("t1_bits", bits_got[3:0], 4'b1000);
        chk("t1_done_cycle", done_c, 7);
        chk("t1_bits_sent_hold", bits_sent, 4);
        chk("t1_period_quiet_short", hit_n, 0);

        // back-pressure in cycles 3..5 delays everything by 3
        launch(4'b0000, 4, 1'b0);
        observe(14, 3, 5, 0, 0, 0);
        chk("t2_count", n_v, 4);
        chk("t2_bits", bits_got[3:0], 4'b1000);
        chk("t2_done_cycle", done_c, 10);
        chk("t2_bits_sent", bits_sent, 4);

        // abort in cycle 4 of a 10-bit burst
        launch(4'b0101, 10, 1'b0);
        observe(14, 0, -1, 4, 0, 0);
        chk("t3_no_done", done_c, -1);
        chk("t3_last_valid", last_v, 4);
        chk("t3_bits_sent_hold", bits_sent, 2);

        // zero-length burst
        launch(4'b0101, 0, 1'b0);
        observe(4, 0, -1, 0, 0, 0);
        chk("t4_zero_done", done_c, 1);
        chk("t4_zero_no_valid", n_v, 0);
        chk("t4_zero_not_busy", busy_n, 0);
        chk("t4_zero_bits_sent", bits_sent, 0);

        // lock-up seed is replaced at capture
        launch(4'b1111, 3, 1'b0);
        observe(8, 0, -1, 0, 0, 0);
        chk("t4_seed_fixed", seed_seen, 4'b1110);
        chk("t4_seed_bits", bits_got[2:0], 3'b111);
        chk("t4_seed_done", done_c, 6);

        // start together with abort is dropped
        launch(4'b0011, 5, 1'b1);
        observe(5, 0, -1, 0, 0, 0);
        chk("start_abort_busy", busy_n, 0);
        chk("start_abort_done", done_c, -1);

        // start during a burst is ignored
        launch(4'b0110, 5, 1'b0);
        observe(12, 0, -1, 0, 0, 3);
        chk("start_busy_done", done_c, 8);
        chk("start_busy_count", n_v, 5);

        // single-bit burst
        launch(4'b1001, 1, 1'b0);
        observe(6, 0, -1, 0, 0, 0);
        chk("one_bit_valid", first_v, 3);
        chk("one_bit_done", done_c, 4);

        // reset mid-RUN, then a clean burst
        launch(4'b0000, 10, 1'b0);
        observe(7, 0, -1, 0, 4, 0);
        chk("t5_no_done", done_c, -1);
        launch(4'b0000, 4, 1'b0);
        observe(10, 0, -1, 0, 0, 0);
        chk("t5_bits", bits_got[3:0], 4'b1000);
        chk("t5_done_cycle", done_c, 7);
        chk("t5_bits_sent", bits_sent, 4);

        // full period: one hit only when the detector is built in
        launch(4'b0000, 20, 1'b0);
        observe(26, 0, -1, 0, 0, 0);
        chk("t6_done_cycle", done_c, 23);
`ifdef PERIOD_CHECK_EN
        chk("t6_hit_count", hit_n, 1);
        chk("t6_hit_cycle", hit_c, 18);
        chk("t6_period_model", period_len, ref_period(4'b0000));
        chk("t6_period_literal", period_len, 15);
`else
        chk("t6_hit_off", hit_n, 0);
        chk("t6_len_off", period_len, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end
endmodule
